// File: rtl/dnn_accel_sram_dualport.sv
// ---------------------------------------------------------------------------
// dnn_accel_sram_dualport
//   Dual-port on-chip SRAM with two independent Avalon-MM slaves (s1, s2),
//   shared between the host CPU and the accelerator datapath.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   clken, reset_req       block enable is clken & ~reset_req; when low,
//                          nothing is accepted and every pipeline stage holds
//   sN_address             word address (ADDR_WIDTH)
//   sN_chipselect/read/write  command; write wins over read on the same port
//   sN_byteenable          per-byte write lanes (DATA_WIDTH/8)
//   sN_writedata           write data
//   sN_readdata            read data, held at last valid value between results
//   sN_readdatavalid       one pulse per accepted read, latency 1 or 2
//                          enabled cycles (OUTPUT_REG)
//
// Same-cycle collisions: the other port's read sees the old word; two writes
// to one address merge per lane with s1 winning shared lanes. Addresses at or
// above DEPTH are dropped on write and read back as zero.
// ---------------------------------------------------------------------------
module dnn_accel_sram_dualport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 8192,
  parameter int OUTPUT_REG = 0,
  parameter     INIT_FILE  = "dnn_accel_sram_dualport.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int unsigned         NB   = DATA_WIDTH / 8;
  localparam int                  IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIM  = (ADDR_WIDTH + 1)'(DEPTH);

  // Contents are loaded at configuration by the FPGA memory-init flow.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_en;
  logic w_acc;

  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic                  w_cs    [2];
  logic                  w_rdq   [2];
  logic                  w_wrq   [2];
  logic [NB-1:0]         w_be    [2];
  logic [DATA_WIDTH-1:0] w_wdata [2];

  logic                  w_wr    [2];
  logic                  w_rd    [2];
  logic                  w_inr   [2];
  logic [IDXW-1:0]       w_idx   [2];
  logic                  w_vlast [2];
  logic [DATA_WIDTH-1:0] w_dlast [2];
  logic                  w_vout  [2];
  logic [DATA_WIDTH-1:0] w_dout  [2];

  assign w_en  = clken & ~reset_req;
  assign w_acc = w_en & ~reset;

  always_comb begin
    w_addr[0]  = s1_address;
    w_cs[0]    = s1_chipselect;
    w_rdq[0]   = s1_read;
    w_wrq[0]   = s1_write;
    w_be[0]    = s1_byteenable;
    w_wdata[0] = s1_writedata;
    w_addr[1]  = s2_address;
    w_cs[1]    = s2_chipselect;
    w_rdq[1]   = s2_read;
    w_wrq[1]   = s2_write;
    w_be[1]    = s2_byteenable;
    w_wdata[1] = s2_writedata;
  end

  // Lane-wise write. s1 is applied after s2 so the later non-blocking update
  // gives s1 the shared lanes when both ports hit the same word.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (w_wr[1] && w_inr[1] && w_be[1][b])
        r_mem[w_idx[1]][8*b +: 8] <= w_wdata[1][8*b +: 8];
      if (w_wr[0] && w_inr[0] && w_be[0][b])
        r_mem[w_idx[0]][8*b +: 8] <= w_wdata[0][8*b +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;
    logic [DATA_WIDTH-1:0] r_hold;

    assign w_wr[p]  = w_acc & w_cs[p] & w_wrq[p];
    assign w_rd[p]  = w_acc & w_cs[p] & w_rdq[p] & ~w_wrq[p];
    assign w_inr[p] = ({1'b0, w_addr[p]} < LIM);
    assign w_idx[p] = w_addr[p][IDXW-1:0];

    // Array read samples pre-write contents: mixed-port read returns old data.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_v1 <= 1'b0;
        r_d1 <= '0;
      end else if (w_en) begin
        r_v1 <= w_rd[p];
        if (w_rd[p]) r_d1 <= w_inr[p] ? r_mem[w_idx[p]] : '0;
      end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] r_d2;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else if (w_en) begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign w_vlast[p] = r_v2;
      assign w_dlast[p] = r_d2;
    end else begin : g_direct
      assign w_vlast[p] = r_v1;
      assign w_dlast[p] = r_d1;
    end

    // A pending stage is only presented in an enabled, non-reset cycle; the
    // pipeline register may already hold the next word while stalled, so the
    // visible readdata comes from r_hold until the result is actually shown.
    assign w_vout[p] = w_vlast[p] & w_acc;
    assign w_dout[p] = w_vout[p] ? w_dlast[p] : r_hold;

    always_ff @(posedge clk) begin
      if (reset)          r_hold <= '0;
      else if (w_vout[p]) r_hold <= w_dlast[p];
    end
  end

  assign s1_readdata      = w_dout[0];
  assign s1_readdatavalid = w_vout[0];
  assign s2_readdata      = w_dout[1];
  assign s2_readdatavalid = w_vout[1];

endmodule

// File: doc/dnn_accel_sram_dualport.md
Name: dnn_accel_sram_dualport

Overview:
- Parametrised dual-port on-chip SRAM for the DNN accelerator system, with two independent Avalon-MM slaves: s1 and s2.
- Typical uses are instruction/weight storage shared between the host CPU and the accelerator datapath.
- Adds configurable width and depth, an optional output register and a per-port readdatavalid pipeline.
- Defines byte-lane write collision and read-during-write behaviour.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 13, word address width.
- DEPTH, 8192, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- OUTPUT_REG, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
- INIT_FILE, "dnn_accel_sram_dualport.hex", initial contents loaded at configuration.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  global clock enable; 0 stalls the whole block.
- reset_req  in  1  reset-request; when 1, acts as clken=0.
- s1_address  in  ADDR_WIDTH  port 1 word address.
- s1_chipselect  in  1  port 1 select.
- s1_read  in  1  port 1 read request.
- s1_write  in  1  port 1 write request.
- s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes.
- s1_writedata  in  DATA_WIDTH  port 1 write data.
- s1_readdata  out  DATA_WIDTH  port 1 read data.
- s1_readdatavalid  out  1  port 1 read data valid.
- s2_*  same set, widths and meanings as s1_*, for port 2.

Behaviour:
- Enable: en = clken & ~reset_req. When en=0:
  - no write is performed and no read is accepted;
  - every pipeline register, including pending valid bits, holds its value;
  - readdatavalid outputs are forced to 0.
  - When en returns to 1, a held valid stage presents its data, with readdatavalid=1, in the first enabled cycle.
- Reset: synchronous. In any cycle with reset=1:
  - all valid bits and readdata registers clear to 0;
  - writes are ignored;
  - memory contents are preserved;
  - reads in flight when reset asserts are dropped and never produce readdatavalid.
- Command accept: in an enabled cycle with reset=0, a port accepts a write when chipselect&write, and a read when chipselect&read&~write.
  - Write has priority: if read and write are both high, only the write is performed and no readdatavalid results.
- Write: only lanes with byteenable[i]=1 update bits [8i+7:8i]. A write with byteenable all-zero changes nothing.
- Read latency, counted in enabled cycles:
  - OUTPUT_REG=0: readdata and readdatavalid=1 in the enabled cycle after accept.
  - OUTPUT_REG=1: two enabled cycles after accept.
  - Back-to-back reads sustain one result per enabled cycle per port, with no waitrequest.
- readdata holds its last valid value when readdatavalid=0; it is not cleared except by reset.
- Read-during-write, same port: not possible, because write has priority.
- Read-during-write, mixed ports: a read on one port to an address written by the other port in the same cycle returns the OLD data.
- Write collision: s1 and s2 writing the same address in the same cycle resolve per byte lane.
  - s1 wins on lanes both ports enable.
  - Lanes enabled by only one port take that port's data.
- Out of range: an address >= DEPTH is ignored on write. On read it returns 0, with readdatavalid still asserted at normal latency.
- Both ports are fully independent otherwise. Simultaneous reads of the same address both return the same word.

Test Plan:
- Basic write/read, OUTPUT_REG=0: s1 write 0xDEADBEEF to addr 5 with be=0xF, then s1 read addr 5 -> s1_readdatavalid=1 exactly one cycle after accept, s1_readdata=0xDEADBEEF.
- Byte enable: from addr 5=0xDEADBEEF, s2 write 0x11223344 with be=0x5, then read -> 0xDE22BE44.
- Collision: same cycle, s1 writes 0xAAAAAAAA with be=0x3 and s2 writes 0xBBBBBBBB with be=0xF, both to addr 9 -> read returns 0xBBBBAAAA.
  - Separately, s2 reads addr 9 while s1 writes it -> old value returned.
- Latency and stall, OUTPUT_REG=1: s1 reads addrs 0,1,2 back-to-back -> valid data appears in cycles +2, +3, +4.
  - Repeat with clken=0 for 3 cycles after the 2nd accept -> readdatavalid=0 during the stall, then results 1 and 2 resume in order, with no loss or duplication.
- Reset mid-read: reset=1 the cycle after a read accept -> no readdatavalid, readdata=0, and memory contents unchanged on a later read.
- Out of range, DEPTH=6000: write to 6500, then read 6500 -> readdatavalid=1 with readdata=0.
  - Also check read+write asserted together -> write only, no readdatavalid.
